dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data-cache controller sitting between the CPU memory stage and the 32-line x 256-bit data SRAM, with the 256-bit-wide data memory behind it. It holds tag/valid/dirty state internally and drives the SRAM port. It stalls the CPU on misses and sequences write-back and line-fill transactions to memory.

Parameters:
LINES, 32, number of cache lines; index width is log2(LINES)=5
TAG_W, 22, tag width = 32 - 5 index - 5 offset
LINE_W, 256, line width in bits (8 x 32-bit words)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-low
p1_addr_i  in  32  CPU byte address; [4:2] word select, [9:5] index, [31:10] tag; [1:0] ignored
p1_data_i  in  32  CPU write data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  32  load data
p1_stall_o  out  1  CPU stall
sram_addr_o  out  5  data SRAM index
sram_data_o  out  256  data SRAM write line
sram_enable_o  out  1  data SRAM enable
sram_write_o  out  1  data SRAM write (SRAM commits on negedge)
sram_data_i  in  256  data SRAM read line (combinational)
mem_addr_o  out  32  memory line address, [4:0]=0
mem_data_o  out  256  write-back line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1=write-back, 0=fill
mem_data_i  in  256  fill line, valid in ack cycle
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=0): state IDLE; all valid/dirty bits cleared; tags 0; line buffer 0; every output 0. Reset mid-transaction aborts it; mem_enable_o drops immediately.
- req = MemRead|MemWrite. If both are set, write takes precedence. CPU holds addr/data/req stable while p1_stall_o=1.
- hit = valid[idx] & (tag[idx]==p1_addr_i[31:10]).
- sram_addr_o = idx in all states. sram_enable_o = req or state != IDLE.
- States:
  - IDLE:
    - Read hit: p1_data_o = sram_data_i word [4:2], same cycle; stall 0.
    - Write hit: sram_write_o=1; sram_data_o = sram_data_i with word [4:2] replaced by p1_data_i; dirty[idx]<=1; stall 0.
    - Miss with dirty victim: go to WRITEBACK. Miss with clean/invalid victim: go to READMISS.
    - p1_stall_o = req & ~hit, combinationally in IDLE.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={tag[idx],idx,5'b0}, mem_data_o=sram_data_i. On mem_ack_i go to READMISS.
  - READMISS: mem_enable_o=1, mem_write_o=0, mem_addr_o={p1_addr_i[31:5],5'b0}. On mem_ack_i latch mem_data_i into the line buffer and go to READMISSOK.
  - READMISSOK: sram_write_o=1, sram_data_o=line buffer; tag<=new tag; valid<=1; dirty<=0; go to IDLE. The next cycle is a hit and completes the original access, including store merge and dirty set.
- p1_stall_o=1 in every non-IDLE state.
- mem_enable_o is held until the ack cycle and is low the cycle after. An ack arriving in IDLE or READMISSOK is ignored.
- p1_data_o = 0 when not a read hit.
- Minimum miss latency: clean miss = memory latency + 2 cycles of stall; dirty miss adds the write-back latency.

Test Plan:
- Reset: hold rst_i=0 mid-clock -> all outputs 0 asynchronously. Release, read 0x404 -> miss, mem_addr_o=0x400, mem_write_o=0.
- Cold read miss: read 0x404, memory returns line with word1=0x11111111 after 10 cycles -> stall through READMISSOK, then p1_data_o=0x11111111 with stall 0, with no further memory traffic.
- Write hit: write 0xDEADBEEF to 0x404 -> no stall, sram_write_o=1 for one cycle, dirty set. Read 0x404 -> 0xDEADBEEF.
- Dirty eviction: read 0x804 (index 0, tag 2) -> WRITEBACK to 0x400 with mem_data_o word1=0xDEADBEEF, then fill from 0x800, then data returned.
- Clean conflict: read 0xC04 after the previous step with no store -> no WRITEBACK, fill from 0xC00 only. Simultaneous read+write to a hit -> treated as write.
- Reset in READMISS: assert rst_i during fill -> mem_enable_o=0 immediately. Re-read 0x404 -> miss again (valid cleared).

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate data-cache controller.
// Holds tag/valid/dirty state, drives the line SRAM and sequences write-back and fill to memory.
//
// state      | meaning
// IDLE       | serve hits; detect misses
// WRITEBACK  | dirty victim line being written to memory
// READMISS   | fill of the requested line from memory
// READMISSOK | filled line committed to SRAM; access retried next cycle
module dcache_controller #(
  parameter int LINES  = 32,
  parameter int TAG_W  = 22,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  output logic [$clog2(LINES)-1:0] sram_addr_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [LINE_W-1:0] sram_data_i,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {IDLE, WRITEBACK, READMISS, READMISSOK} state_t;

  state_t              state, state_nxt;
  logic [LINES-1:0]    valid, dirty;
  logic [TAG_W-1:0]    tags [LINES];
  logic [LINE_W-1:0]   line_buf;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag_in;
  logic [2:0]          word;
  logic                req, rd_req, wr_req, hit;
  logic [LINE_W-1:0]   merged;
  logic                unused_addr_bits;

  logic [31:0]         p1_data_c;
  logic                stall_c, sram_write_c, mem_enable_c, mem_write_c;
  logic [LINE_W-1:0]   sram_data_c, mem_data_c;
  logic [31:0]         mem_addr_c;
  logic                dirty_set, buf_load, fill_done;

  assign idx    = p1_addr_i[5 +: IDX_W];
  assign tag_in = p1_addr_i[31 -: TAG_W];
  assign word   = p1_addr_i[4:2];
  assign req    = p1_MemRead_i | p1_MemWrite_i;
  assign wr_req = p1_MemWrite_i;
  assign rd_req = p1_MemRead_i & ~p1_MemWrite_i;
  assign hit    = valid[idx] & (tags[idx] == tag_in);
  assign unused_addr_bits = ^p1_addr_i[1:0];

  always_comb begin
    merged = sram_data_i;
    merged[{word, 5'b0} +: 32] = p1_data_i;
  end

  always_comb begin
    state_nxt    = state;
    p1_data_c    = '0;
    stall_c      = 1'b1;
    sram_write_c = 1'b0;
    sram_data_c  = '0;
    mem_enable_c = 1'b0;
    mem_write_c  = 1'b0;
    mem_addr_c   = '0;
    mem_data_c   = '0;
    dirty_set    = 1'b0;
    buf_load     = 1'b0;
    fill_done    = 1'b0;
    case (state)
      IDLE: begin
        stall_c = req & ~hit;
        if (req && hit) begin
          if (wr_req) begin
            sram_write_c = 1'b1;
            sram_data_c  = merged;
            dirty_set    = 1'b1;
          end else if (rd_req) begin
            p1_data_c = sram_data_i[{word, 5'b0} +: 32];
          end
        end else if (req) begin
          state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : READMISS;
        end
      end
      WRITEBACK: begin
        mem_enable_c = 1'b1;
        mem_write_c  = 1'b1;
        mem_addr_c   = {tags[idx], idx, 5'b0};
        mem_data_c   = sram_data_i;
        if (mem_ack_i) state_nxt = READMISS;
      end
      READMISS: begin
        mem_enable_c = 1'b1;
        mem_addr_c   = {p1_addr_i[31:5], 5'b0};
        if (mem_ack_i) begin
          buf_load  = 1'b1;
          state_nxt = READMISSOK;
        end
      end
      READMISSOK: begin
        sram_write_c = 1'b1;
        sram_data_c  = line_buf;
        fill_done    = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      line_buf <= '0;
      for (int i = 0; i < LINES; i++) tags[i] <= '0;
    end else begin
      state <= state_nxt;
      if (buf_load) line_buf <= mem_data_i;
      if (dirty_set) dirty[idx] <= 1'b1;
      if (fill_done) begin
        tags[idx]  <= tag_in;
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Outputs are forced low while reset is asserted so an in-flight request drops at once.
  assign p1_data_o     = rst_i ? p1_data_c : '0;
  assign p1_stall_o    = rst_i & stall_c;
  assign sram_addr_o   = rst_i ? idx : '0;
  assign sram_data_o   = rst_i ? sram_data_c : '0;
  assign sram_enable_o = rst_i & (req | (state != IDLE));
  assign sram_write_o  = rst_i & sram_write_c;
  assign mem_addr_o    = rst_i ? mem_addr_c : '0;
  assign mem_data_o    = rst_i ? mem_data_c : '0;
  assign mem_enable_o  = rst_i & mem_enable_c;
  assign mem_write_o   = rst_i & mem_write_c;

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random accesses against a
// behavioural write-back cache model; SRAM and memory are modelled around the DUT.
module tb_dcache_controller;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [31:0]  p1_addr_i = '0, p1_data_i = '0;
  logic         p1_MemRead_i = 1'b0, p1_MemWrite_i = 1'b0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [4:0]   sram_addr_o;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_enable_o, sram_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_enable_o, mem_write_o;
  logic         mem_ack_i = 1'b0;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .sram_addr_o(sram_addr_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_data_i(sram_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input logic [31:0] line_addr);
    logic [255:0] l;
    for (int w = 0; w < 8; w++)
      l[w*32 +: 32] = ((line_addr | (w << 2)) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    return l;
  endfunction

  // Line SRAM: combinational read, write committed on the falling edge.
  logic [255:0] sram [32];
  initial for (int i = 0; i < 32; i++) sram[i] = '0;
  assign sram_data_i = sram[sram_addr_o];
  always @(negedge clk_i) if (sram_enable_o && sram_write_o) sram[sram_addr_o] <= sram_data_o;

  // Main memory with a programmable latency; every completed transaction is logged.
  typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } txn_t;
  logic [255:0] phys_mem [logic [31:0]];
  txn_t         log_q[$];
  int           mem_lat = 0;
  int           cnt = 0;
  bit           busy = 0;
  bit           cur_wr;
  logic [31:0]  cur_addr;

  function automatic logic [255:0] phys_get(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      mem_ack_i = 1'b0;
      busy = 0;
    end else begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        busy = 0;
      end
      if (mem_enable_o) begin
        if (!busy) begin
          busy = 1; cnt = mem_lat; cur_addr = mem_addr_o; cur_wr = mem_write_o;
        end
        if (cnt == 0) begin
          txn_t t;
          t.wr = cur_wr; t.addr = cur_addr; t.data = cur_wr ? mem_data_o : '0;
          log_q.push_back(t);
          if (cur_wr) phys_mem[cur_addr] = mem_data_o;
          else mem_data_i = phys_get(cur_addr);
          mem_ack_i = 1'b1;
        end else cnt--;
      end else busy = 0;
    end
  end

  // Reference: architectural write-back cache at line granularity.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  logic [255:0] m_data  [32];
  logic [255:0] ref_mem [logic [31:0]];

  function automatic logic [255:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    logic [255:0] l;
    logic [31:0] la = {addr[31:5], 5'b0};
    int w = int'(addr[4:2]);
    l = ref_get(la); l[w*32 +: 32] = val; ref_mem[la] = l;
    l = phys_get(la); l[w*32 +: 32] = val; phys_mem[la] = l;
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                        input bit rd, input bit wr, input int lat);
    int idx = int'(addr[9:5]);
    int w = int'(addr[4:2]);
    logic [21:0] tag = addr[31:10];
    logic [31:0] la = {addr[31:5], 5'b0};
    bit hit = m_valid[idx] && (m_tag[idx] == tag);
    txn_t exp_q[$];
    txn_t t;
    int exp_stall, stalls;
    bit done;
    logic [31:0] exp_rd;

    exp_stall = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        t.wr = 1; t.addr = {m_tag[idx], addr[9:5], 5'b0}; t.data = m_data[idx];
        exp_q.push_back(t);
        ref_mem[t.addr] = m_data[idx];
        exp_stall = 2 * lat + 4;
      end else exp_stall = lat + 3;
      t.wr = 0; t.addr = la; t.data = '0;
      exp_q.push_back(t);
      m_data[idx] = ref_get(la);
      m_tag[idx] = tag; m_valid[idx] = 1; m_dirty[idx] = 0;
    end
    if (wr) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1;
    end
    exp_rd = (rd && !wr) ? m_data[idx][w*32 +: 32] : 32'h0;

    mem_lat = lat;
    log_q.delete();
    p1_addr_i = addr; p1_data_i = wdata; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    stalls = 0; done = 0;
    while (!done && stalls < 300) begin
      @(negedge clk_i);
      if (!p1_stall_o) begin
        done = 1;
        check_val("load_data", p1_data_o, exp_rd);
        check_val("sram_write_on_hit", sram_write_o, wr);
      end else stalls++;
    end
    check_val("access_done", done, 1);
    @(posedge clk_i); #1;
    p1_MemRead_i = 0; p1_MemWrite_i = 0;
    check_val("stall_cycles", stalls, exp_stall);
    check_val("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_val("txn_wr", log_q[i].wr, exp_q[i].wr);
      check_val("txn_addr", log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) check_val("wb_data", log_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    int waited;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    p1_addr_i = 32'h404; p1_MemRead_i = 1'b1;
    @(negedge clk_i);
    check_val("miss_stall_before_reset", p1_stall_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check_val("rst_stall", p1_stall_o, 0);
    check_val("rst_p1_data", p1_data_o, 0);
    check_val("rst_sram_enable", sram_enable_o, 0);
    check_val("rst_sram_write", sram_write_o, 0);
    check_val("rst_sram_addr", sram_addr_o, 0);
    check_val("rst_mem_enable", mem_enable_o, 0);
    check_val("rst_mem_write", mem_write_o, 0);
    check_val("rst_mem_addr", mem_addr_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    model_reset();

    preload(32'h404, 32'h11111111);
    access(32'h404, 32'h0, 1, 0, 10);
    access(32'h404, 32'hDEADBEEF, 0, 1, 2);
    @(negedge clk_i);
    check_val("sram_write_one_cycle", sram_write_o, 0);
    @(posedge clk_i); #1;
    access(32'h404, 32'h0, 1, 0, 3);
    access(32'h804, 32'h0, 1, 0, 4);
    access(32'hC04, 32'h0, 1, 0, 2);
    access(32'h424, 32'h0, 1, 0, 1);
    access(32'h424, 32'hCAFEF00D, 1, 1, 1);
    access(32'h424, 32'h0, 1, 0, 0);

    mem_lat = 8;
    p1_addr_i = 32'h404; p1_MemRead_i = 1'b1;
    waited = 0;
    do begin @(negedge clk_i); waited++; end while (!mem_enable_o && waited < 20);
    check_val("fill_started", mem_enable_o, 1);
    @(posedge clk_i); #2 rst_i = 1'b0;
    #1;
    check_val("abort_mem_enable", mem_enable_o, 0);
    check_val("abort_stall", p1_stall_o, 0);
    p1_MemRead_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;
    model_reset();
    access(32'h404, 32'h0, 1, 0, 2);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      int op;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 2);
      access(a, $urandom, op != 1, op != 0, $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
